// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station: bus widths, branch opcodes,
// operand/CDB payloads and the tag-wakeup helper.
package branch_rs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 6;

    typedef logic [OP_W-1:0]   op_bus_t;
    typedef logic [TAG_W-1:0]  tag_bus_t;
    typedef logic [DATA_W-1:0] data_bus_t;

    localparam tag_bus_t NO_TAG  = '0;
    localparam logic     ENABLE  = 1'b1;
    localparam logic     DISABLE = 1'b0;

    localparam op_bus_t OP_BEQ  = 6'h00;
    localparam op_bus_t OP_BNE  = 6'h01;
    localparam op_bus_t OP_BLT  = 6'h04;
    localparam op_bus_t OP_BGE  = 6'h05;
    localparam op_bus_t OP_BLTU = 6'h06;
    localparam op_bus_t OP_BGEU = 6'h07;

    typedef struct packed {
        tag_bus_t  tag;
        data_bus_t val;
    } operand_t;

    typedef struct packed {
        logic      en;
        tag_bus_t  tag;
        data_bus_t data;
    } cdb_t;

    typedef struct packed {
        logic      valid;
        op_bus_t   op;
        operand_t  opd_o;
        operand_t  opd_t;
        data_bus_t imm;
        data_bus_t pc;
    } rs_entry_t;

    typedef struct packed {
        op_bus_t   op;
        data_bus_t opd_o;
        data_bus_t opd_t;
        data_bus_t imm;
        data_bus_t pc;
    } issue_t;

    // Capture a broadcast into a waiting operand; ALU wins when both buses match.
    function automatic operand_t wake(operand_t o, cdb_t alu, cdb_t lsu);
        operand_t r;
        r = o;
        if (o.tag != NO_TAG) begin
            if (alu.en && (alu.tag == o.tag)) begin
                r = '{tag: NO_TAG, val: alu.data};
            end else if (lsu.en && (lsu.tag == o.tag)) begin
                r = '{tag: NO_TAG, val: lsu.data};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB and issue signals between the pipeline and the branch RS.
interface branch_rs_if;
    import branch_rs_pkg::*;

    logic      dispatch_en;
    op_bus_t   dispatch_op;
    data_bus_t dispatch_valO;
    data_bus_t dispatch_valT;
    tag_bus_t  dispatch_tagO;
    tag_bus_t  dispatch_tagT;
    data_bus_t dispatch_imm;
    data_bus_t dispatch_pc;
    logic      rs_full;

    logic      alu_cdb_en;
    tag_bus_t  alu_cdb_tag;
    data_bus_t alu_cdb_data;
    logic      lsu_cdb_en;
    tag_bus_t  lsu_cdb_tag;
    data_bus_t lsu_cdb_data;

    logic      BranchWorkEn;
    data_bus_t operandO;
    data_bus_t operandT;
    data_bus_t imm;
    data_bus_t PC;
    op_bus_t   opCode;

    modport slave (
        input  dispatch_en, dispatch_op, dispatch_valO, dispatch_valT,
               dispatch_tagO, dispatch_tagT, dispatch_imm, dispatch_pc,
               alu_cdb_en, alu_cdb_tag, alu_cdb_data,
               lsu_cdb_en, lsu_cdb_tag, lsu_cdb_data,
        output rs_full, BranchWorkEn, operandO, operandT, imm, PC, opCode
    );

    modport master (
        output dispatch_en, dispatch_op, dispatch_valO, dispatch_valT,
               dispatch_tagO, dispatch_tagT, dispatch_imm, dispatch_pc,
               alu_cdb_en, alu_cdb_tag, alu_cdb_data,
               lsu_cdb_en, lsu_cdb_tag, lsu_cdb_data,
        input  rs_full, BranchWorkEn, operandO, operandT, imm, PC, opCode
    );

endinterface

// File: rtl/rs_entry_select.sv
// Combinational lowest-index finder over a request vector.
module rs_entry_select #(
    parameter  int unsigned ENTRIES = 4,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] req_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched branches until both operands are
// valid, then issues the lowest-index ready entry to the Branch unit.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    branch_rs_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    rs_entry_t          ent_q [ENTRIES];
    rs_entry_t          ent_d [ENTRIES];
    issue_t             out_q, out_d;
    logic               work_q, work_d;
    logic               full_q, full_d;

    logic [ENTRIES-1:0] free_vec, rdy_vec;
    logic               free_found, rdy_found;
    logic [IDX_W-1:0]   free_idx, rdy_idx;
    cdb_t               alu_cdb, lsu_cdb;

    assign alu_cdb = '{en: bus.alu_cdb_en, tag: bus.alu_cdb_tag, data: bus.alu_cdb_data};
    assign lsu_cdb = '{en: bus.lsu_cdb_en, tag: bus.lsu_cdb_tag, data: bus.lsu_cdb_data};

    // Readiness is judged on registered state, so a wakeup at edge N issues at N+1.
    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            free_vec[i] = ~ent_q[i].valid;
            rdy_vec[i]  = ent_q[i].valid && (ent_q[i].opd_o.tag == NO_TAG)
                                         && (ent_q[i].opd_t.tag == NO_TAG);
        end
    end

    rs_entry_select #(.ENTRIES(ENTRIES)) u_free_sel (
        .req_i   (free_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_entry_select #(.ENTRIES(ENTRIES)) u_rdy_sel (
        .req_i   (rdy_vec),
        .found_o (rdy_found),
        .idx_o   (rdy_idx)
    );

    always_comb begin
        ent_d  = ent_q;
        out_d  = out_q;
        work_d = DISABLE;
        full_d = 1'b1;

        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].opd_o = wake(ent_q[i].opd_o, alu_cdb, lsu_cdb);
                ent_d[i].opd_t = wake(ent_q[i].opd_t, alu_cdb, lsu_cdb);
            end
        end

        if (rdy_found) begin
            work_d = ENABLE;
            out_d  = '{op:    ent_q[rdy_idx].op,
                       opd_o: ent_q[rdy_idx].opd_o.val,
                       opd_t: ent_q[rdy_idx].opd_t.val,
                       imm:   ent_q[rdy_idx].imm,
                       pc:    ent_q[rdy_idx].pc};
            ent_d[rdy_idx].valid = 1'b0;
        end

        // Free slot comes from registered state, so an issuing slot is never reused this edge.
        if (bus.dispatch_en && !full_q && free_found) begin
            ent_d[free_idx] = '{valid: 1'b1,
                                op:    bus.dispatch_op,
                                opd_o: wake('{tag: bus.dispatch_tagO, val: bus.dispatch_valO},
                                            alu_cdb, lsu_cdb),
                                opd_t: wake('{tag: bus.dispatch_tagT, val: bus.dispatch_valT},
                                            alu_cdb, lsu_cdb),
                                imm:   bus.dispatch_imm,
                                pc:    bus.dispatch_pc};
        end

        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!ent_d[i].valid) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= '0;
            out_q  <= '0;
            work_q <= DISABLE;
            full_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= ent_d[i];
            out_q  <= out_d;
            work_q <= work_d;
            full_q <= full_d;
        end
    end

    assign bus.rs_full      = full_q;
    assign bus.BranchWorkEn = work_q;
    assign bus.opCode       = out_q.op;
    assign bus.operandO     = out_q.opd_o;
    assign bus.operandT     = out_q.opd_t;
    assign bus.imm          = out_q.imm;
    assign bus.PC           = out_q.pc;

endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Reservation station for conditional branches. It sits between dispatch and the Branch execute unit.
- Holds up to ENTRIES dispatched branch instructions. Each entry waits for its two source operands to arrive on the ALU and LSU common data buses (CDB).
- Issues one ready entry per cycle to Branch, which receives operandO, operandT, opCode, imm and PC plus BranchWorkEn.

Parameters:
- ENTRIES, 4, number of RS slots; must be a power of 2 and at least 2.
- DATA_W, 32, operand, immediate and PC width.
- TAG_W, 4, rename-tag width. Tag value 0 is reserved and means the operand value is already valid.
- OP_W, 6, opcode width; matches the shared OpBus.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dispatch_en  in  1  write a new branch this cycle.
- dispatch_op  in  OP_W  BEQ/BNE/BLT/BGE/BLTU/BGEU code.
- dispatch_valO, dispatch_valT  in  DATA_W  operand values; meaningful only when the matching tag is 0.
- dispatch_tagO, dispatch_tagT  in  TAG_W  producer tags; 0 means ready.
- dispatch_imm, dispatch_pc  in  DATA_W  branch offset and instruction PC.
- rs_full  out  1  no free slot; dispatch must stall.
- alu_cdb_en, alu_cdb_tag, alu_cdb_data  in  1/TAG_W/DATA_W  ALU result broadcast.
- lsu_cdb_en, lsu_cdb_tag, lsu_cdb_data  in  1/TAG_W/DATA_W  load result broadcast.
- BranchWorkEn  out  1  one-cycle issue strobe to Branch.
- operandO, operandT, imm, PC  out  DATA_W  issued entry fields.
- opCode  out  OP_W  issued entry opcode.

Behaviour:
- Reset (asynchronous, rst low):
  - All entry valid bits clear.
  - BranchWorkEn=0; operandO, operandT, imm, PC and opCode all 0.
  - rs_full=0.
  - Reset mid-operation discards all entries with no issue.
- Per-entry state: valid, op, valO, tagO, valT, tagT, imm, pc. An entry is ready when valid=1, tagO=0 and tagT=0.
- Dispatch:
  - When dispatch_en=1 and rs_full=0, write the lowest-index free slot at the clock edge.
  - When dispatch_en=1 and rs_full=1, ignore the request and leave state unchanged.
- Dispatch-time forwarding:
  - If a dispatched tag is nonzero and equals an active CDB tag in the same cycle, store that CDB data with tag=0.
  - ALU CDB has priority if both CDBs match.
- Wakeup:
  - Every valid entry with tagX equal to an active CDB tag captures the data and sets tagX=0 at that edge.
  - Both operands of one entry may wake in the same cycle, from the same or different buses.
  - Tag 0 never matches a broadcast.
- Issue select: the lowest-index entry that is ready at the start of the cycle.
  - Operands woken at edge N make the entry eligible in cycle N+1.
- Issue timing and outputs:
  - At the edge, register the selected entry's fields onto the outputs, set BranchWorkEn=1 for exactly one cycle, and clear that entry's valid bit.
  - If no entry is ready, BranchWorkEn=0 and the data outputs hold their previous values.
- Latency:
  - Dispatch with both tags 0 at edge N gives BranchWorkEn high in the cycle following edge N+1.
  - Minimum RS residency is two edges.
- Simultaneous events:
  - Issue and dispatch in the same cycle are both allowed. A slot freed by issue becomes reusable from the next cycle, not the same edge.
  - A CDB broadcast to an entry that issues at the same edge is harmless; that entry was already ready.
- rs_full: registered. Equals 1 when, after the edge, all ENTRIES valid bits are set.
- Throughput: one issue per cycle at most.
- No flush input. The pipeline stalls fetch on unresolved branches, so no speculative entries exist.

Decomposition:
- Shared package/defines holds:
  - OpBus width and branch opcodes BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - TagBus, the reserved tag constant noTag=0, DataBus, Enable/Disable.
- One natural sub-module: rs_entry_select.
  - Combinational lowest-index finder, parameterised by ENTRIES.
  - Instantiated twice: once for the free slot and once for the ready slot.
  - Each instance returns a found bit and an index.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, dispatch_en=1 → no writes, BranchWorkEn=0, rs_full=0, all outputs 0.
- Ready dispatch: BEQ with valO=5, valT=5, tags 0, imm=8, pc=0x100 at edge 0 → at edge 1 BranchWorkEn=1, opCode=BEQ, operandO=5, operandT=5, imm=8, PC=0x100; next cycle BranchWorkEn=0.
- Wakeup: BLT with tagO=3, tagT=0, valT=7; two cycles later alu_cdb_en=1, tag=3, data=0xFFFFFFFF → issue one edge later with operandO=0xFFFFFFFF, operandT=7.
- Same-cycle forward: dispatch tagO=5 while lsu_cdb_en=1, tag=5, data=42; second operand ready → issues next edge with operandO=42.
- Full: dispatch 4 entries all with tagO=9 → rs_full=1; a fifth dispatch is dropped; alu_cdb tag=9 → entries 0..3 issue on 4 consecutive cycles in index order; rs_full drops after the first issue.
- Priority: ALU and LSU both broadcast tag=2 with data 10 and 20 to an entry waiting on tag 2 → entry captures 10.
